// File: rtl/maze_port_arbiter.sv
// Round-robin arbiter sharing the maze tile memory read port between N_REQ requesters.
// One read is in flight at a time; out-of-range coordinates return the wall code with unchanged timing.
module maze_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAZE_W  = 28,
    parameter int MAZE_H  = 31,
    parameter int TILE_W  = 2,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [5*N_REQ-1:0]   req_x,
    input  logic [5*N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [TILE_W-1:0]    rsp_data,
    output logic                 busy,
    output logic                 mem_en,
    output logic [4:0]           mem_x,
    output logic [4:0]           mem_y,
    input  logic [TILE_W-1:0]    mem_rdata
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               oor_q, oor_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [TILE_W-1:0]  rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic               mem_en_q, mem_en_d;
    logic [4:0]         mem_x_q, mem_x_d;
    logic [4:0]         mem_y_q, mem_y_d;

    logic [4:0]         x_arr [N_REQ];
    logic [4:0]         y_arr [N_REQ];
    logic               found;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   lane;
    logic               pick_ok;
    int                 idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            x_arr[i] = req_x[5*i +: 5];
            y_arr[i] = req_y[5*i +: 5];
        end
    end

    // First requesting lane at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        lane  = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            lane = PTR_W'(idx);
            if (!found && req[lane]) begin
                found = 1'b1;
                pick  = lane;
            end
        end
        pick_ok = ({1'b0, x_arr[pick]} < 6'(MAZE_W)) && ({1'b0, y_arr[pick]} < 6'(MAZE_H));
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        oor_d       = oor_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        mem_en_d    = 1'b0;
        mem_x_d     = mem_x_q;
        mem_y_d     = mem_y_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = ISSUE;
                    win_d    = pick;
                    mem_x_d  = x_arr[pick];
                    mem_y_d  = y_arr[pick];
                    oor_d    = !pick_ok;
                    mem_en_d = pick_ok;
                    gnt_d    = N_REQ'(1) << pick;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(1);
            end
            WAIT: begin
                if (cnt_q == CNT_W'(MEM_LAT)) begin
                    // Out-of-range reads take the same path so the response timing never changes.
                    rsp_data_d  = oor_q ? '1 : mem_rdata;
                    rsp_valid_d = N_REQ'(1) << win_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            oor_q       <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_x_q     <= '0;
            mem_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            oor_q       <= oor_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_x_q     <= mem_x_d;
            mem_y_q     <= mem_y_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_x     = mem_x_q;
    assign mem_y     = mem_y_q;

endmodule
